// File: rtl/regx_arb.sv
// regx_arb: two-requester arbiter for the regx register window (FF80h-FFFFh).
// The CPU xdata port and the I2C/SSE slave port compete for one register-file
// access port. Round-robin on ties; each access is a registered CMD strobe
// followed by an ack (write: CMD, DONE; read: CMD, DATA, DONE).
//
// Ports
//   clk, rrst               : clock, synchronous active-high reset
//   m_req/m_wr/m_addr/m_wdat: CPU request (only REGX_BASE window accepted)
//   m_ack, m_rdat           : CPU one-cycle ack, held read data
//   s_req/s_wr/s_addr/s_wdat: slave request (s_addr is a window offset)
//   s_ack, s_rdat           : slave one-cycle ack, held read data
//   regx_r/regx_w           : register-file read command / write strobe
//   regx_addr/regx_wdat     : offset / write data, valid in the command cycle
//   regx_rdat               : register-file read data, one cycle after regx_r
//   xb_idle                 : high while the arbiter is idle
module regx_arb #(
  parameter logic [8:0] REGX_BASE = 9'h1FF
) (
  input  logic       clk,
  input  logic       rrst,
  input  logic       m_req,
  input  logic       m_wr,
  input  logic [15:0] m_addr,
  input  logic [7:0] m_wdat,
  output logic       m_ack,
  output logic [7:0] m_rdat,
  input  logic       s_req,
  input  logic       s_wr,
  input  logic [6:0] s_addr,
  input  logic [7:0] s_wdat,
  output logic       s_ack,
  output logic [7:0] s_rdat,
  output logic       regx_r,
  output logic       regx_w,
  output logic [6:0] regx_addr,
  output logic [7:0] regx_wdat,
  input  logic [7:0] regx_rdat,
  output logic       xb_idle
);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  state_t     state;
  logic       gnt_s;    // current winner: 1 = slave, 0 = CPU
  logic       lat_wr;   // latched direction of the current access
  logic       last_s;   // last grant went to the slave

  logic       m_vld;
  logic       pick_s;
  logic       sel_wr;
  logic [6:0] sel_addr;
  logic [7:0] sel_wdat;

  // CPU accesses outside the window are not ours; they are never acked.
  assign m_vld = m_req && (m_addr[15:7] == REGX_BASE);

  // Slave wins when alone, or on a tie when the CPU had the last grant.
  always_comb begin
    pick_s   = s_req && (!m_vld || !last_s);
    sel_wr   = pick_s ? s_wr   : m_wr;
    sel_addr = pick_s ? s_addr : m_addr[6:0];
    sel_wdat = pick_s ? s_wdat : m_wdat;
  end

  // Outputs are loaded on the transition into the state that shows them, so
  // every strobe, ack and xb_idle is a flop aligned with its state.
  always_ff @(posedge clk) begin
    if (rrst) begin
      state     <= IDLE;
      gnt_s     <= 1'b0;
      lat_wr    <= 1'b0;
      last_s    <= 1'b1;
      m_ack     <= 1'b0;
      s_ack     <= 1'b0;
      m_rdat    <= 8'h00;
      s_rdat    <= 8'h00;
      regx_r    <= 1'b0;
      regx_w    <= 1'b0;
      regx_addr <= 7'h00;
      regx_wdat <= 8'h00;
      xb_idle   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (m_vld || s_req) begin
            gnt_s     <= pick_s;
            last_s    <= pick_s;
            lat_wr    <= sel_wr;
            regx_r    <= !sel_wr;
            regx_w    <= sel_wr;
            regx_addr <= sel_addr;
            regx_wdat <= sel_wdat;
            xb_idle   <= 1'b0;
            state     <= CMD;
          end
        end
        CMD: begin
          regx_r    <= 1'b0;
          regx_w    <= 1'b0;
          regx_addr <= 7'h00;
          regx_wdat <= 8'h00;
          if (lat_wr) begin
            m_ack <= !gnt_s;
            s_ack <= gnt_s;
            state <= DONE;
          end else begin
            state <= DATA;
          end
        end
        DATA: begin
          // regx_rdat answers the previous cycle's read command.
          if (gnt_s) s_rdat <= regx_rdat;
          else       m_rdat <= regx_rdat;
          m_ack <= !gnt_s;
          s_ack <= gnt_s;
          state <= DONE;
        end
        DONE: begin
          m_ack   <= 1'b0;
          s_ack   <= 1'b0;
          xb_idle <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          state   <= IDLE;
          xb_idle <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regx_arb.sv
// tb_regx_arb: randomized + directed bench for regx_arb. A transaction-level
// model predicts, per cycle, the strobes, acks, idle flag and read data.
module tb_regx_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rrst;
  logic m_req, m_wr, m_ack;
  logic [15:0] m_addr;
  logic [7:0] m_wdat, m_rdat;
  logic s_req, s_wr, s_ack;
  logic [6:0] s_addr;
  logic [7:0] s_wdat, s_rdat;
  logic regx_r, regx_w, xb_idle;
  logic [6:0] regx_addr;
  logic [7:0] regx_wdat, regx_rdat;

  regx_arb #(.REGX_BASE(9'h1FF)) dut (
    .clk(clk), .rrst(rrst),
    .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_wdat(m_wdat),
    .m_ack(m_ack), .m_rdat(m_rdat),
    .s_req(s_req), .s_wr(s_wr), .s_addr(s_addr), .s_wdat(s_wdat),
    .s_ack(s_ack), .s_rdat(s_rdat),
    .regx_r(regx_r), .regx_w(regx_w), .regx_addr(regx_addr),
    .regx_wdat(regx_wdat), .regx_rdat(regx_rdat), .xb_idle(xb_idle)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // requester behaviour (index 0 = CPU, 1 = slave)
  logic        rq[2], rwr[2];
  logic [15:0] raddr[2];
  logic [7:0]  rwd[2];
  bit          granted[2], drop_nx[2];
  int          miss_cnt;
  bit          rand_en, persist;
  logic [7:0]  rdat_fix;
  bit          rdat_fix_en;

  // transaction-level reference model
  bit         cur_v;
  int         t0, t_ack, who, last;
  bit         cwr;
  logic [6:0] coff;
  logic [7:0] cwd, cdat;
  logic [7:0] exp_rd[2];
  bit         pend_rst;
  int         gq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Advance one clock, then compare every output against the model.
  task automatic tick();
    bit cmd, busy;
    @(posedge clk); #1; cyc++;
    if (pend_rst) begin
      pend_rst = 0; cur_v = 0; last = 1;
      exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
      for (int i = 0; i < 2; i++) begin
        rq[i] = 0; granted[i] = 0; drop_nx[i] = 0;
      end
    end
    if (cur_v && cyc > t_ack) cur_v = 0;
    if (cur_v && cyc == t_ack && !cwr) exp_rd[who] = cdat;
    cmd  = cur_v && cyc == t0 + 1;
    busy = cur_v && cyc > t0 && cyc <= t_ack;
    chk("regx_r",    32'(regx_r),    32'(cmd && !cwr));
    chk("regx_w",    32'(regx_w),    32'(cmd && cwr));
    chk("regx_addr", 32'(regx_addr), cmd ? 32'(coff) : 32'h0);
    chk("regx_wdat", 32'(regx_wdat), cmd ? 32'(cwd) : 32'h0);
    chk("m_ack",     32'(m_ack),     32'(cur_v && cyc == t_ack && who == 0));
    chk("s_ack",     32'(s_ack),     32'(cur_v && cyc == t_ack && who == 1));
    chk("xb_idle",   32'(xb_idle),   32'(!busy));
    chk("m_rdat",    32'(m_rdat),    32'(exp_rd[0]));
    chk("s_rdat",    32'(s_rdat),    32'(exp_rd[1]));
    if (cur_v && cyc == t_ack) drop_nx[who] = 1;
  endtask

  task automatic raise(input int i, input bit inwin);
    rq[i]    = 1;
    rwr[i]   = 1'($urandom);
    rwd[i]   = 8'($urandom);
    raddr[i] = {9'h1FF, 7'($urandom)};
    if (i == 0 && !inwin) begin
      raddr[0][15:7] = 9'($urandom_range(0, 510));
      miss_cnt = $urandom_range(1, 6);
    end
  endtask

  // Requester reactions for the coming cycle.
  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      if (drop_nx[i]) begin
        rq[i] = 0; drop_nx[i] = 0; granted[i] = 0;
      end else if (rq[i] && granted[i]) begin
        // once granted, the request fields must no longer matter
        if (rand_en && $urandom_range(0, 1) == 1) begin
          rwr[i] = 1'($urandom); raddr[i] = 16'($urandom); rwd[i] = 8'($urandom);
        end
      end else if (rq[i] && i == 0 && raddr[0][15:7] != 9'h1FF) begin
        miss_cnt--;
        if (miss_cnt <= 0) rq[0] = 0;
      end else if (!rq[i] && (persist || (rand_en && $urandom_range(0, 3) == 0))) begin
        raise(i, persist || $urandom_range(0, 3) != 0);
      end
    end
  endtask

  // Apply inputs for this cycle and let the model arbitrate on them.
  task automatic commit();
    bit v0, v1;
    m_req = rq[0]; m_wr = rwr[0]; m_addr = raddr[0]; m_wdat = rwd[0];
    s_req = rq[1]; s_wr = rwr[1]; s_addr = raddr[1][6:0]; s_wdat = rwd[1];
    regx_rdat = rdat_fix_en ? rdat_fix : 8'($urandom);
    if (cur_v && !cwr && cyc == t0 + 2) cdat = regx_rdat;
    if (rrst) begin
      pend_rst = 1;
    end else if (!cur_v) begin
      v0 = rq[0] && raddr[0][15:7] == 9'h1FF;
      v1 = rq[1];
      if (v0 || v1) begin
        who   = (v0 && v1) ? (last == 1 ? 0 : 1) : (v1 ? 1 : 0);
        cur_v = 1; t0 = cyc;
        cwr   = rwr[who]; coff = raddr[who][6:0]; cwd = rwd[who];
        t_ack = cyc + (cwr ? 2 : 3);
        last  = who; granted[who] = 1;
        gq.push_back(who);
      end
    end
  endtask

  task automatic step();
    drive(); commit(); tick();
  endtask

  initial begin
    rrst = 1; rand_en = 0; persist = 0; rdat_fix_en = 0; rdat_fix = 8'h00;
    last = 1; cur_v = 0; pend_rst = 0; miss_cnt = 0;
    for (int i = 0; i < 2; i++) begin
      rq[i] = 0; rwr[i] = 0; raddr[i] = 16'h0; rwd[i] = 8'h0;
      granted[i] = 0; drop_nx[i] = 0; exp_rd[i] = 8'h00;
    end
    commit(); tick();
    commit(); tick();
    rrst = 0;

    // CPU write FF93 <- 5A
    rq[0] = 1; rwr[0] = 1; raddr[0] = 16'hFF93; rwd[0] = 8'h5A;
    commit(); tick();
    chk("wr_strobe", 32'(regx_w), 32'h1);
    chk("wr_addr",   32'(regx_addr), 32'h13);
    chk("wr_wdat",   32'(regx_wdat), 32'h5A);
    step();
    chk("wr_ack",    32'(m_ack), 32'h1);
    repeat (2) step();

    // CPU read FFA0, register returns 3C
    rq[0] = 1; rwr[0] = 0; raddr[0] = 16'hFFA0; rdat_fix_en = 1; rdat_fix = 8'h3C;
    commit(); tick();
    chk("rd_cmd",  32'(regx_r), 32'h1);
    chk("rd_addr", 32'(regx_addr), 32'h20);
    step(); step();
    chk("rd_ack",  32'(m_ack), 32'h1);
    chk("rd_data", 32'(m_rdat), 32'h3C);
    rdat_fix_en = 0;
    repeat (2) step();

    // CPU access outside the window, held for 10 cycles
    rq[0] = 1; rwr[0] = 1; raddr[0] = 16'hFE93; miss_cnt = 10;
    commit(); tick();
    for (int k = 0; k < 9; k++) begin
      step();
      chk("miss_idle", 32'(xb_idle), 32'h1);
      chk("miss_w",    32'(regx_w), 32'h0);
    end
    repeat (3) step();

    // both requesters from reset release: CPU, slave, CPU
    rrst = 1; step();
    gq.delete();
    rrst = 0; persist = 1;
    raise(0, 1); raise(1, 1);
    commit(); tick();
    repeat (14) step();
    persist = 0;
    repeat (8) step();
    chk("rr_count", 32'(gq.size() >= 3), 32'h1);
    if (gq.size() >= 3) begin
      chk("rr_gnt0", 32'(gq[0]), 32'h0);
      chk("rr_gnt1", 32'(gq[1]), 32'h1);
      chk("rr_gnt2", 32'(gq[2]), 32'h0);
    end

    // reset during the DATA cycle of a slave read
    rq[1] = 1; rwr[1] = 0; raddr[1] = 16'h0045; rwd[1] = 8'h00;
    commit(); tick();
    step();
    rrst = 1; commit(); tick();
    chk("rst_s_ack",  32'(s_ack), 32'h0);
    chk("rst_s_rdat", 32'(s_rdat), 32'h0);
    chk("rst_idle",   32'(xb_idle), 32'h1);
    rrst = 0;
    repeat (4) step();

    // randomized traffic with occasional resets
    rand_en = 1;
    for (int k = 0; k < 3000; k++) begin
      rrst = ($urandom_range(0, 99) == 0);
      step();
    end
    rrst = 0; rand_en = 0;
    repeat (12) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regx_arb.md
REGX_ARB -- requirements
Module: regx_arb

Interface
REQ-001 SHALL have parameter REGX_BASE, default 9'h1FF, meaning the CPU xdata address bits [15:7] that select the regx window FF80h-FFFFh.
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rrst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port m_req  input  1  CPU xdata request, level, held until m_ack.
REQ-005 SHALL have port m_wr  input  1  CPU direction, 1 = write, 0 = read.
REQ-006 SHALL have port m_addr  input  16  CPU xdata address.
REQ-007 SHALL have port m_wdat  input  8  CPU write data.
REQ-008 SHALL have port m_ack  output  1  one-cycle CPU completion pulse.
REQ-009 SHALL have port m_rdat  output  8  CPU read data, held until the next CPU read completes.
REQ-010 SHALL have ports s_req/s_wr (input 1 each), s_addr (input 7), s_wdat (input 8), s_ack (output 1), s_rdat (output 8), with the m_* meanings for the I2C/SSE slave requester; s_addr is already a window offset.
REQ-011 SHALL have port regx_r  output  1  read command, high in the command cycle of a read.
REQ-012 SHALL have port regx_w  output  1  write strobe, high in the command cycle of a write.
REQ-013 SHALL have port regx_addr  output  7  register offset, valid in the command cycle.
REQ-014 SHALL have port regx_wdat  output  8  write data, valid in the command cycle.
REQ-015 SHALL have port regx_rdat  input  8  register-file read data, valid one cycle after the read command cycle.
REQ-016 SHALL have port xb_idle  output  1  high when the FSM is in IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, CMD, DATA, DONE, all registered.
REQ-018 SHALL treat the CPU as requesting only when m_req=1 and m_addr[15:7]==REGX_BASE; other CPU accesses are ignored and never acked.
REQ-019 SHALL, in IDLE, sample the requests; if any is valid, latch winner, wr, offset (m_addr[6:0] or s_addr) and wdat, then go to CMD.
REQ-020 SHALL arbitrate round-robin on simultaneous requests: grant the requester not granted last; a lone requester always wins; last-grant flag updates on every grant.
REQ-021 SHALL, in CMD, drive regx_addr/regx_wdat from the latched values and assert exactly one of regx_r (read) or regx_w (write); next state is DATA for a read, DONE for a write.
REQ-022 SHALL, in DATA, capture regx_rdat into the winner's rdat register at the end of the cycle; the other requester's rdat is unchanged.
REQ-023 SHALL, in DONE, assert the winner's ack for exactly one cycle and return to IDLE.
REQ-024 SHALL give latency, from the first IDLE cycle seeing the request to ack: write 2 cycles, read 3 cycles; m_rdat/s_rdat valid in the ack cycle.
REQ-025 SHALL require the requester to drop req in the cycle after ack; req still high in that IDLE cycle starts a new transaction (back-to-back allowed, one IDLE cycle between).
REQ-026 SHALL ignore changes to req/addr/wdat/wr of either requester outside IDLE.
REQ-027 SHALL keep regx_r, regx_w, m_ack, s_ack at 0 in all states other than those listed above; regx_addr/regx_wdat SHALL be 0 outside CMD.
REQ-028 SHALL never assert regx_r and regx_w together, and never assert m_ack and s_ack together.

Reset
REQ-029 SHALL, while rrst=1 at a clock edge, enter IDLE, clear latches, m_rdat=s_rdat=8'h00, all strobes/acks 0, last-grant flag = slave (CPU wins the first tie), xb_idle=1.
REQ-030 SHALL abandon an in-flight transaction on reset with no ack and no further regx_r/regx_w.

Verification
REQ-031 CPU write m_addr=16'hFF93, m_wdat=8'h5A -> regx_w=1, regx_addr=7'h13, regx_wdat=8'h5A in cycle 1; m_ack in cycle 2.
REQ-032 CPU read m_addr=16'hFFA0, regx_rdat=8'h3C in cycle 2 -> regx_r in cycle 1, m_ack with m_rdat=8'h3C in cycle 3.
REQ-033 m_req with m_addr=16'hFE93 for 10 cycles -> no regx_r/regx_w, no m_ack, xb_idle stays 1.
REQ-034 m_req and s_req both held from reset release -> grants alternate CPU, slave, CPU; each ack pairs with the correct requester.
REQ-035 rrst=1 in the DATA cycle of a slave read -> no s_ack, s_rdat=8'h00, xb_idle=1 on the next cycle.
